// File: rtl/map_context_engine.sv
// Save/restore engine for the 4510 mapper state: walks the mapper register view to/from a memory buffer.
// Optional MAP_CTX_CHECKSUM_EN adds a 5th checksum byte and aborts restores whose checksum mismatches.
module map_context_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic        save_req,
    input  logic        restore_req,
    input  logic [19:0] base_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  map_reg_sel,
    input  logic [7:0]  map_reg,
    output logic [7:0]  map_data,
    output logic        load_a,
    output logic        load_x,
    output logic        load_y,
    output logic        load_z,
    output logic [19:0] mem_addr,
    output logic [7:0]  mem_data_o,
    input  logic [7:0]  mem_data_i,
    output logic        mem_we,
    output logic        mem_re,
    input  logic        ready
);

`ifdef MAP_CTX_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
`else
    localparam logic [2:0] LAST_BYTE = 3'd3;
`endif
    localparam logic [7:0] CHK_SEED = 8'hA5;

    typedef enum logic [2:0] {IDLE, SAVE, FETCH, COMMIT, DONE} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [19:0] base_reg, base_next;
    logic [7:0]  sum_reg, sum_next;
    logic        err_reg, err_next;
    logic        shadow_we;
    logic [3:0]  load_vec;
    logic [7:0]  shadow_reg [0:3];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            base_reg  <= 20'd0;
            sum_reg   <= 8'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            base_reg  <= base_next;
            sum_reg   <= sum_next;
            err_reg   <= err_next;
        end
    end

    // Shadow bytes need no reset: they are only read in COMMIT after a full fetch.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
            always_ff @(posedge clk) begin
                if (!reset && shadow_we && cnt_reg[1:0] == 2'(gi))
                    shadow_reg[gi] <= mem_data_i;
            end
        end
    endgenerate

    assign load_a = load_vec[0];
    assign load_x = load_vec[1];
    assign load_y = load_vec[2];
    assign load_z = load_vec[3];

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        base_next   = base_reg;
        sum_next    = sum_reg;
        err_next    = err_reg;
        shadow_we   = 1'b0;
        busy        = (state_reg != IDLE);
        done        = 1'b0;
        error       = 1'b0;
        map_reg_sel = 2'd0;
        map_data    = 8'd0;
        load_vec    = 4'd0;
        mem_addr    = 20'd0;
        mem_data_o  = 8'd0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next = 3'd0;
                sum_next = 8'd0;
                err_next = 1'b0;
                if (save_req) begin
                    base_next  = base_addr;
                    state_next = SAVE;
                end else if (restore_req) begin
                    base_next  = base_addr;
                    state_next = FETCH;
                end
            end
            SAVE: begin
                map_reg_sel = cnt_reg[1:0];
                mem_addr    = base_reg + 20'(cnt_reg);
                mem_we      = 1'b1;
                mem_data_o  = map_reg;
`ifdef MAP_CTX_CHECKSUM_EN
                if (cnt_reg[2])
                    mem_data_o = sum_reg ^ CHK_SEED;
`endif
                if (ready) begin
                    sum_next = sum_reg ^ map_reg;
                    if (cnt_reg == LAST_BYTE) begin
                        cnt_next   = 3'd0;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end
            FETCH: begin
                mem_addr = base_reg + 20'(cnt_reg);
                mem_re   = 1'b1;
                if (ready) begin
                    shadow_we = !cnt_reg[2];
                    sum_next  = sum_reg ^ mem_data_i;
                    if (cnt_reg == LAST_BYTE) begin
                        cnt_next   = 3'd0;
                        state_next = COMMIT;
`ifdef MAP_CTX_CHECKSUM_EN
                        if (mem_data_i != (sum_reg ^ CHK_SEED)) begin
                            err_next   = 1'b1;
                            state_next = DONE;
                        end
`endif
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end
            COMMIT: begin
                load_vec[cnt_reg[1:0]] = 1'b1;
                map_data = shadow_reg[cnt_reg[1:0]];
                if (cnt_reg == 3'd3) begin
                    cnt_next   = 3'd0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            DONE: begin
                done       = 1'b1;
                error      = err_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_map_context_engine.sv
// Scoreboard bench for map_context_engine: bus writes/reads and mapper loads are queued when a
// request is issued and checked as the engine produces them.
module tb_map_context_engine;

`ifdef MAP_CTX_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        clk = 0;
    logic        reset = 1;
    logic        save_req = 0, restore_req = 0;
    logic [19:0] base_addr = 0;
    logic        busy, done, error;
    logic [1:0]  map_reg_sel;
    logic [7:0]  map_reg;
    logic [7:0]  map_data;
    logic        load_a, load_x, load_y, load_z;
    logic [19:0] mem_addr;
    logic [7:0]  mem_data_o;
    logic [7:0]  mem_data_i = 0;
    logic        mem_we, mem_re;
    logic        ready = 1;

    map_context_engine dut (
        .clk(clk), .reset(reset), .save_req(save_req), .restore_req(restore_req),
        .base_addr(base_addr), .busy(busy), .done(done), .error(error),
        .map_reg_sel(map_reg_sel), .map_reg(map_reg), .map_data(map_data),
        .load_a(load_a), .load_x(load_x), .load_y(load_y), .load_z(load_z),
        .mem_addr(mem_addr), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .mem_we(mem_we), .mem_re(mem_re), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t  wr_q[$];
    ev_t  rd_q[$];
    ev_t  ld_q[$];
    logic [7:0] mem_model [int];
    logic [7:0] mapper_view [4];
    int   n_checks = 0;
    int   n_pass = 0;
    int   ready_mode = 0;

    assign map_reg = mapper_view[map_reg_sel];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ready: always high, or high one cycle in three
    initial begin
        int rcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) ready = 1;
            else begin
                rcnt++;
                ready = (rcnt % 3 == 0);
            end
        end
    end

    // Bus/mapper monitor
    initial begin
        forever begin
            @(negedge clk);
            if (mem_we) begin
                if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    chk("wr_addr", 32'(mem_addr), 32'(wr_q[0].addr));
                    chk("wr_data", 32'(mem_data_o), 32'(wr_q[0].data));
                    if (ready) begin
                        mem_model[int'(mem_addr)] = mem_data_o;
                        void'(wr_q.pop_front());
                    end
                end
            end
            if (mem_re) begin
                mem_data_i = mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : 8'h00;
                if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
                else begin
                    chk("rd_addr", 32'(mem_addr), 32'(rd_q[0].addr));
                    if (ready) void'(rd_q.pop_front());
                end
            end
            if ({load_z, load_y, load_x, load_a} != 4'd0) begin
                logic [3:0] lv;
                int idx;
                lv = {load_z, load_y, load_x, load_a};
                idx = (lv == 4'b0010) ? 1 : (lv == 4'b0100) ? 2 : (lv == 4'b1000) ? 3 : 0;
                if (ld_q.size() == 0) chk("unexpected_load", 32'(lv), 0);
                else begin
                    chk("load_strobe", 32'(lv), 32'(4'b0001 << ld_q[0].addr[1:0]));
                    chk("map_data", 32'(map_data), 32'(ld_q[0].data));
                    void'(ld_q.pop_front());
                end
                mapper_view[idx] = map_data;
            end
        end
    end

    task automatic start(input logic s, input logic r, input logic [19:0] b);
        @(negedge clk);
        save_req = s;
        restore_req = r;
        base_addr = b;
        @(posedge clk);
        #1;
        save_req = 0;
        restore_req = 0;
        base_addr = ~b;
    endtask

    task automatic wait_done(input int exp_cyc, input logic exp_err);
        int cyc = 0;
        logic seen = 0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("busy_rise", 32'(busy), 1);
            if (done) begin
                seen = 1;
                chk("error_at_done", 32'(error), 32'(exp_err));
            end
        end
        chk("done_seen", 32'(seen), 1);
        if (exp_cyc > 0) chk("latency", 32'(cyc), 32'(exp_cyc));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("busy_fall", 32'(busy), 0);
    endtask

    function automatic logic [7:0] csum(input logic [7:0] b0, b1, b2, b3);
        return b0 ^ b1 ^ b2 ^ b3 ^ 8'hA5;
    endfunction

    task automatic push_save(input logic [19:0] b);
        for (int i = 0; i < 4; i++) wr_q.push_back('{b + 20'(i), mapper_view[i]});
        if (NB == 5)
            wr_q.push_back('{b + 20'd4, csum(mapper_view[0], mapper_view[1], mapper_view[2], mapper_view[3])});
    endtask

    task automatic preload(input logic [19:0] b, input logic [7:0] v0, v1, v2, v3);
        mem_model[int'(b)] = v0;
        mem_model[int'(b + 20'd1)] = v1;
        mem_model[int'(b + 20'd2)] = v2;
        mem_model[int'(b + 20'd3)] = v3;
        mem_model[int'(b + 20'd4)] = csum(v0, v1, v2, v3);
    endtask

    task automatic push_reads(input logic [19:0] b);
        for (int i = 0; i < NB; i++) rd_q.push_back('{b + 20'(i), 8'h00});
    endtask

    initial begin
        mapper_view[0] = 8'h12; mapper_view[1] = 8'h34;
        mapper_view[2] = 8'h56; mapper_view[3] = 8'h78;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outputs", 32'({done, error, mem_we, mem_re, load_a, load_x, load_y, load_z}), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        reset = 0;

        // Save with ready always high
        push_save(20'h1F000);
        start(1, 0, 20'h1F000);
        wait_done(NB + 1, 0);
        chk("save_wr_q_empty", 32'(wr_q.size()), 0);
        chk("saved_byte2", 32'(mem_model[32'h1F002]), 32'h56);

        // Restore into a cleared mapper
        preload(20'h1F000, 8'h12, 8'h34, 8'h56, 8'h78);
        for (int i = 0; i < 4; i++) mapper_view[i] = 8'h00;
        push_reads(20'h1F000);
        ld_q.push_back('{20'd0, 8'h12});
        ld_q.push_back('{20'd1, 8'h34});
        ld_q.push_back('{20'd2, 8'h56});
        ld_q.push_back('{20'd3, 8'h78});
        start(0, 1, 20'h1F000);
        wait_done(NB + 5, 0);
        chk("restore_queues_empty", 32'(rd_q.size() + ld_q.size()), 0);
        chk("mapper_readback", 32'({mapper_view[0], mapper_view[1], mapper_view[2], mapper_view[3]}), 32'h12345678);

        // Save with ready 1-in-3: each pair checked every stalled cycle
        mapper_view[0] = 8'hA1; mapper_view[1] = 8'hB2;
        mapper_view[2] = 8'hC3; mapper_view[3] = 8'hD4;
        ready_mode = 1;
        push_save(20'h00100);
        start(1, 0, 20'h00100);
        wait_done(0, 0);
        ready_mode = 0;
        chk("stall_wr_q_empty", 32'(wr_q.size()), 0);

        // Address wrap at top of 20-bit space
        push_save(20'hFFFFE);
        start(1, 0, 20'hFFFFE);
        wait_done(NB + 1, 0);
        chk("wrap_wr_q_empty", 32'(wr_q.size()), 0);
        chk("wrap_byte2", 32'(mem_model[32'h00000]), 32'hC3);

        // Both requests: save only
        push_save(20'h00200);
        start(1, 1, 20'h00200);
        wait_done(NB + 1, 0);
        chk("both_wr_q_empty", 32'(wr_q.size()), 0);

        // Reset while fetching byte 2: mapper untouched
        preload(20'h00300, 8'h01, 8'h02, 8'h03, 8'h04);
        push_reads(20'h00300);
        start(0, 1, 20'h00300);
        begin
            int guard = 0;
            while (!(mem_re && mem_addr == 20'h00302) && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            chk("reached_fetch2", 32'(guard < 50), 1);
        end
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        rd_q.delete();
        @(negedge clk);
        chk("busy_after_reset", 32'(busy), 0);
        repeat (8) @(negedge clk);
        chk("mapper_after_reset", 32'({mapper_view[0], mapper_view[1], mapper_view[2], mapper_view[3]}), 32'hA1B2C3D4);

`ifdef MAP_CTX_CHECKSUM_EN
        // Corrupted byte 2: no loads, done with error
        preload(20'h00400, 8'h11, 8'h22, 8'h33, 8'h44);
        mem_model[32'h00402] = 8'hFF;
        push_reads(20'h00400);
        start(0, 1, 20'h00400);
        wait_done(NB + 1, 1);
        chk("corrupt_rd_q_empty", 32'(rd_q.size()), 0);
        chk("mapper_after_corrupt", 32'({mapper_view[0], mapper_view[1], mapper_view[2], mapper_view[3]}), 32'hA1B2C3D4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
